// File: rtl/comb_circ_tester_if.sv
// Signal bundle between the tester and the bench/board side:
// start/results on one side, A/B/C drive and X return on the other.
interface comb_circ_tester_if;
   logic       start;
   logic       x_i;
   logic       a_o;
   logic       b_o;
   logic       c_o;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_count;
   logic       fail_valid;
   logic [2:0] fail_vec;

   modport master (
      input  start,
      input  x_i,
      output a_o,
      output b_o,
      output c_o,
      output busy,
      output done,
      output pass,
      output err_count,
      output fail_valid,
      output fail_vec
   );

   modport slave (
      output start,
      output x_i,
      input  a_o,
      input  b_o,
      input  c_o,
      input  busy,
      input  done,
      input  pass,
      input  err_count,
      input  fail_valid,
      input  fail_vec
   );
endinterface

// File: rtl/comb_circ_tester.sv
// Walks all eight A/B/C vectors through X = AB | ~B C, waits for the
// circuit to settle, samples X and scores it against a golden model.
module comb_circ_tester #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic                clk,
   input logic                rst_n,
   comb_circ_tester_if.master bus
);
   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [2:0] vec;
   logic [3:0] cnt;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [3:0] err_q;
   logic       fv_q;
   logic [2:0] fvec_q;
   logic       exp_x;
   logic       miss;

   assign exp_x = (vec[2] & vec[1]) | (~vec[1] & vec[0]);
   assign miss  = bus.x_i ^ exp_x;

   assign {bus.a_o, bus.b_o, bus.c_o} = vec;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_q;
   assign bus.fail_valid = fv_q;
   assign bus.fail_vec   = fvec_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         vec    <= 3'd0;
         cnt    <= 4'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         err_q  <= 4'd0;
         fv_q   <= 1'b0;
         fvec_q <= 3'd0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  vec    <= 3'd0;
                  cnt    <= 4'd0;
                  err_q  <= 4'd0;
                  fv_q   <= 1'b0;
                  fvec_q <= 3'd0;
                  pass_q <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == LAST) state <= SAMPLE;
               else             cnt   <= cnt + 4'd1;
            end
            SAMPLE: begin
               if (miss) begin
                  err_q <= err_q + 4'd1;
                  if (!fv_q) begin
                     fvec_q <= vec;
                     fv_q   <= 1'b1;
                  end
               end
               // the only way vec leaves 7 is through DONE
               if (vec == 3'd7) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  vec   <= vec + 3'd1;
                  cnt   <= 4'd0;
                  state <= SETTLE;
               end
            end
            DONE: begin
               pass_q <= (err_q == 4'd0);
               vec    <= 3'd0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_comb_circ_tester.sv
// Bench: two testers (settle 2 with a zero-delay circuit model, settle 1
// with a one-cycle-delay model); run results are scored from a queue.
module tb_comb_circ_tester;
   typedef struct {
      bit pass;
      int err;
      bit fv;
      int fvec;
      int done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   mode0 = 0;
   logic g0;
   logic x1_q = 1'b0;
   exp_t q0[$];
   exp_t q1[$];

   comb_circ_tester_if bus0 ();
   comb_circ_tester_if bus1 ();

   comb_circ_tester #(.SETTLE_CYCLES(2)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.master)
   );

   comb_circ_tester #(.SETTLE_CYCLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // circuit models: dut0 selectable fault, dut1 golden with one cycle lag
   assign g0 = (bus0.a_o & bus0.b_o) | (~bus0.b_o & bus0.c_o);
   assign bus0.x_i = (mode0 == 0) ? g0 :
                     (mode0 == 1) ? 1'b0 :
                     (mode0 == 2) ? 1'b1 : ~g0;
   always @(posedge clk)
      x1_q <= (bus1.a_o & bus1.b_o) | (~bus1.b_o & bus1.c_o);
   assign bus1.x_i = x1_q;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // monitors: score a run when its done pulse shows up
   initial forever begin
      @(negedge clk);
      if (bus0.done) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_done", 1, 0);
         end else begin
            chk("dut0_done_cyc", cyc, q0[0].done_cyc);
            chk("dut0_err_count", int'(bus0.err_count), q0[0].err);
            chk("dut0_fail_valid", int'(bus0.fail_valid), int'(q0[0].fv));
            chk("dut0_fail_vec", int'(bus0.fail_vec), q0[0].fvec);
            chk("dut0_busy_in_done", int'(bus0.busy), 0);
            @(negedge clk);
            chk("dut0_pass", int'(bus0.pass), int'(q0[0].pass));
            chk("dut0_done_width", int'(bus0.done), 0);
            chk("dut0_vec_home", int'({bus0.a_o, bus0.b_o, bus0.c_o}), 0);
            void'(q0.pop_front());
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (bus1.done) begin
         if (q1.size() == 0) begin
            chk("dut1_unexpected_done", 1, 0);
         end else begin
            chk("dut1_done_cyc", cyc, q1[0].done_cyc);
            chk("dut1_err_count", int'(bus1.err_count), q1[0].err);
            @(negedge clk);
            chk("dut1_pass", int'(bus1.pass), int'(q1[0].pass));
            void'(q1.pop_front());
         end
      end
   end

   task automatic run0(input int md, input bit ep, input int ee,
                       input bit efv, input int efvec,
                       input bit restart, input bit step);
      exp_t e;
      mode0 = md;
      @(negedge clk);
      bus0.start = 1'b1;
      e = '{ep, ee, efv, efvec, cyc + 1 + 8 * 3};
      q0.push_back(e);
      @(negedge clk);
      bus0.start = 1'b0;
      chk("start_busy", int'(bus0.busy), 1);
      chk("start_clr_err", int'(bus0.err_count), 0);
      chk("start_clr_fv", int'(bus0.fail_valid), 0);
      chk("start_clr_pass", int'(bus0.pass), 0);
      if (step) begin
         for (int j = 0; j < 24; j++) begin
            chk("step_vec", int'({bus0.a_o, bus0.b_o, bus0.c_o}), j / 3);
            chk("step_busy", int'(bus0.busy), 1);
            @(negedge clk);
         end
      end
      if (restart) begin
         repeat (5) @(negedge clk);
         bus0.start = 1'b1;
         @(negedge clk);
         bus0.start = 1'b0;
      end
      for (int t = 0; t < 80 && q0.size() != 0; t++) @(negedge clk);
      chk("run0_timeout", q0.size(), 0);
   endtask

   initial begin
      exp_t e;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      #1;
      chk("rst_abc", int'({bus0.a_o, bus0.b_o, bus0.c_o}), 0);
      chk("rst_busy", int'(bus0.busy), 0);
      chk("rst_done", int'(bus0.done), 0);
      chk("rst_pass", int'(bus0.pass), 0);
      chk("rst_err", int'(bus0.err_count), 0);
      chk("rst_fv", int'(bus0.fail_valid), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run0(0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);
      run0(1, 1'b0, 4, 1'b1, 1, 1'b0, 1'b0);
      run0(2, 1'b0, 4, 1'b1, 0, 1'b0, 1'b0);
      run0(0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);

      // async reset while vector 4 is settling
      mode0 = 0;
      @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      repeat (12) @(negedge clk);
      chk("pre_rst_vec", int'({bus0.a_o, bus0.b_o, bus0.c_o}), 4);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_abc", int'({bus0.a_o, bus0.b_o, bus0.c_o}), 0);
      chk("arst_busy", int'(bus0.busy), 0);
      chk("arst_pass", int'(bus0.pass), 0);
      chk("arst_err", int'(bus0.err_count), 0);
      chk("arst_fv", int'(bus0.fail_valid), 0);
      chk("arst_fvec", int'(bus0.fail_vec), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run0(0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);

      run0(3, 1'b0, 8, 1'b1, 0, 1'b1, 1'b0);
      repeat (30) @(negedge clk);

      @(negedge clk);
      bus1.start = 1'b1;
      e = '{1'b1, 0, 1'b0, 0, cyc + 1 + 8 * 2};
      q1.push_back(e);
      @(negedge clk);
      bus1.start = 1'b0;
      for (int t = 0; t < 60 && q1.size() != 0; t++) @(negedge clk);
      chk("run1_timeout", q1.size(), 0);

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/comb_circ_tester.md
Name: comb_circ_tester

Overview:
Self-checking stimulus/response engine for the lab's 3-input combinational circuit, X = (A & B) | (~B & C). On `start` it drives all eight A/B/C input combinations in order. After each one it waits a programmable settle time for the circuit's gate delays, samples X, and compares it against an internal golden model. It reports pass/fail, the error count and the first failing vector. It sits on the board/bench side of the circuit: it drives the circuit's inputs and reads its output.

Parameters:
SETTLE_CYCLES, 2, clock cycles to wait after each input change before sampling X; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  level/pulse; sampled only in IDLE; begins a test run
x_i  input  1  output X of the circuit under test
a_o  output  1  drive to circuit input A
b_o  output  1  drive to circuit input B
c_o  output  1  drive to circuit input C
busy  output  1  high while a run is in progress (SETTLE or SAMPLE)
done  output  1  single-cycle pulse when a run completes
pass  output  1  high when the last completed run had zero mismatches
err_count  output  4  number of mismatching vectors in the current/last run, 0..8
fail_valid  output  1  high once at least one mismatch has been recorded
fail_vec  output  3  {A,B,C} of the first mismatching vector

Behaviour:
- Clock and reset: one clock domain; all state is registered on the rising edge of clk.
- Reset: while rst_n=0, asynchronously and immediately force:
  - state=IDLE, vec=0, cnt=0
  - a_o=b_o=c_o=0
  - busy=0, done=0, pass=0
  - err_count=0, fail_valid=0, fail_vec=0
- Input drive: {a_o,b_o,c_o} = vec, a 3-bit register, with a_o as the MSB. The drive is direct from the register, with no combinational path from inputs.
- Golden model: exp = (vec[2] & vec[1]) | (~vec[1] & vec[0]).
  - Expected X per vector 0..7 = 0,1,0,0,0,1,1,1.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start=1: vec<=0, cnt<=0, err_count<=0, fail_valid<=0, fail_vec<=0, pass<=0, go to SETTLE.
  - Otherwise hold all outputs; pass and the error results from the last run stay visible.
- SETTLE:
  - If cnt==SETTLE_CYCLES-1, go to SAMPLE; otherwise cnt<=cnt+1.
  - vec is held constant.
- SAMPLE:
  - Compare x_i to exp(vec).
  - On mismatch: err_count<=err_count+1.
  - On a mismatch while fail_valid=0: fail_vec<=vec and fail_valid<=1. Later mismatches do not overwrite fail_vec.
  - If vec==7, go to DONE.
  - Otherwise vec<=vec+1, cnt<=0, go to SETTLE.
- DONE, one cycle only:
  - done=1.
  - pass<=(err_count==0), using the final count including the last sample.
  - vec<=0, so the drive returns to 000.
  - Go to IDLE.
- busy is 1 exactly in SETTLE and SAMPLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES cycles in SETTLE plus 1 in SAMPLE.
  - For a start sampled at edge k: busy is high for cycles k+1 .. k+8*(SETTLE_CYCLES+1).
  - done is high in cycle k+8*(SETTLE_CYCLES+1)+1.
- Width rule: err_count is 4 bits wide and its maximum is 8, so it cannot overflow. vec wraps 7->0 only through DONE, never by incrementing.
- start while busy or in DONE: ignored, with no restart or extension of the run. start held high continuously re-triggers a new run on the first IDLE cycle after DONE.
- Reset mid-run: aborts immediately to reset values. No done pulse; pass=0.
- x_i is assumed stable at the SAMPLE edge. It is not synchronised, because the circuit under test runs combinationally on the same clock.

Test Plan:
1. Golden circuit model on x_i, SETTLE_CYCLES=2, start pulsed for 1 cycle -> a/b/c step through 000..111, each held 3 cycles; done pulses 25 cycles after the start edge; pass=1, err_count=0, fail_valid=0.
2. x_i stuck at 0 -> err_count=4 (vectors 1,5,6,7), fail_vec=3'b001, fail_valid=1, pass=0.
3. x_i stuck at 1 -> err_count=4 (vectors 0,2,3,4), fail_vec=3'b000, pass=0. Then a golden model with a new start -> results clear at start; pass=1, err_count=0.
4. x_i = ~golden -> err_count=8, fail_vec=0, pass=0. Also, start re-pulsed during busy -> no change to timing; a single done pulse.
5. rst_n driven low asynchronously (between clock edges) while vec=4 in SETTLE -> all outputs are 0 immediately, with no clock edge needed. After release and a new start, the run restarts from vec=0 with a full 25-cycle duration.
6. SETTLE_CYCLES=1 with a circuit model having 1 cycle of delay on X -> pass=1; done pulses 17 cycles after the start edge.
